mmu_banked: RTL and testbench

Parametrised memory-management unit for the C128-style system bus. It is the successor to the fixed 8722 MMU and adds a configurable number of preconfiguration registers (PCR) with load-configuration (LCR) strobes. It also adds zero-page and stack relocation pointers with two-stage commit, common-RAM forcing, and a translated address/bank output. It sits between the CPU bus and the RAM/ROM decode logic. All register state is updated on `clk`.

---
 rtl/mmu_banked.sv | 215 +++++++++++++++++++++
 tb/tb_mmu_banked.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_banked.sv
// -----------------------------------------------------------------------------
// mmu_banked
//
// Parametrised memory-management unit for a C128-style system bus. It holds a
// configuration register (CR), NUM_PCR preconfiguration registers (PCR) that
// can be copied into CR through load-configuration (LCR) strobes, a mode
// register (MCR), a common-RAM register (RCR) and zero-page / stack relocation
// pointers with a two-stage commit. Every CPU address is translated
// combinationally into a physical address (ma) and a RAM bank (ram_bank).
//
// Ports
//   clk       in     system clock, all state changes on the rising edge
//   reset     in     synchronous active-high reset
//   rw        in     1 = read, 0 = write
//   addr      in     CPU address
//   d         inout  data bus, driven only for a read that hits a register
//   reg_hit   out    addr falls in the main or the mirror register window
//   cr        out    current configuration register
//   ram_bank  out    effective RAM bank for the current access
//   ma        out    translated address
// -----------------------------------------------------------------------------
module mmu_banked #(
    parameter logic [15:0] BASE    = 16'hD500,
    parameter logic [15:0] MIRROR  = 16'hFF00,
    parameter int          NUM_PCR = 4,
    parameter int          BANK_W  = 2,
    parameter logic [7:0]  VERSION = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rw,
    input  logic [15:0]       addr,
    inout  wire  [7:0]        d,
    output logic              reg_hit,
    output logic [7:0]        cr,
    output logic [BANK_W-1:0] ram_bank,
    output logic [15:0]       ma
);

    // Main window layout: CR, PCR[0..N-1], MCR, RCR, P0L, P0H, P1L, P1H, VR.
    localparam int OFF_MCR    = NUM_PCR + 1;
    localparam int OFF_RCR    = NUM_PCR + 2;
    localparam int OFF_P0L    = NUM_PCR + 3;
    localparam int OFF_P0H    = NUM_PCR + 4;
    localparam int OFF_P1L    = NUM_PCR + 5;
    localparam int OFF_P1H    = NUM_PCR + 6;
    localparam int OFF_VR     = NUM_PCR + 7;
    localparam int MAIN_LEN   = NUM_PCR + 8;
    // Mirror window layout: CR, LCR[0..N-1].
    localparam int MIRROR_LEN = NUM_PCR + 1;

    // -------------------------------------------------------------------------
    // Register state
    // -------------------------------------------------------------------------
    logic [7:0] cr_q;
    logic [7:0] pcr [NUM_PCR];
    logic [7:0] mcr_q;
    logic [7:0] rcr_q;
    logic [7:0] p0l_q, p0h_q, hold0_q;
    logic [7:0] p1l_q, p1h_q, hold1_q;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [15:0] main_off;
    logic [15:0] mirror_off;
    logic        main_hit;
    logic        mirror_hit;
    logic [3:0]  main_idx;
    logic [3:0]  mirror_idx;

    // Offsets are modular, so an address below the window base wraps to a
    // large value and falls outside the window length.
    assign main_off   = addr - BASE;
    assign mirror_off = addr - MIRROR;
    assign main_hit   = (main_off < 16'(MAIN_LEN));
    // The main window takes precedence when the two windows overlap.
    assign mirror_hit = !main_hit && (mirror_off < 16'(MIRROR_LEN));
    assign reg_hit    = main_hit || mirror_hit;
    assign main_idx   = main_off[3:0];
    assign mirror_idx = mirror_off[3:0];

    // -------------------------------------------------------------------------
    // Read path (combinational)
    // -------------------------------------------------------------------------
    logic [7:0] rdata;

    always_comb begin
        // NOTE: every variable assigned in an always_comb gets a default first,
        // otherwise an unassigned path infers a latch.
        rdata = 8'h00;
        if (main_hit) begin
            if (main_idx == 4'd0)              rdata = cr_q;
            for (int i = 0; i < NUM_PCR; i++) begin
                if (main_idx == 4'(i + 1))     rdata = pcr[i];
            end
            if (main_idx == 4'(OFF_MCR))       rdata = mcr_q;
            if (main_idx == 4'(OFF_RCR))       rdata = rcr_q;
            if (main_idx == 4'(OFF_P0L))       rdata = p0l_q;
            if (main_idx == 4'(OFF_P0H))       rdata = p0h_q;   // committed, not hold
            if (main_idx == 4'(OFF_P1L))       rdata = p1l_q;
            if (main_idx == 4'(OFF_P1H))       rdata = p1h_q;   // committed, not hold
            if (main_idx == 4'(OFF_VR))        rdata = VERSION;
        end else if (mirror_hit) begin
            if (mirror_idx == 4'd0)            rdata = cr_q;
            // LCR reads return the PCR contents without loading CR.
            for (int i = 0; i < NUM_PCR; i++) begin
                if (mirror_idx == 4'(i + 1))   rdata = pcr[i];
            end
        end
    end

    assign d = (rw && reg_hit) ? rdata : 8'bz;

    // -------------------------------------------------------------------------
    // Write path
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            cr_q    <= 8'h00;
            // NOTE: the PCR file is a handful of flops, not a RAM macro, so it
            // is reset element by element like any other register.
            for (int i = 0; i < NUM_PCR; i++) pcr[i] <= 8'h00;
            mcr_q   <= 8'h00;
            rcr_q   <= 8'h00;
            p0l_q   <= 8'h00;
            p0h_q   <= 8'h00;
            hold0_q <= 8'h00;
            // Stack pointer resets to its identity page so translation is a
            // pass-through out of reset.
            p1l_q   <= 8'h01;
            p1h_q   <= 8'h00;
            hold1_q <= 8'h00;
        end else if (!rw && main_hit) begin
            if (main_idx == 4'd0) cr_q <= d;
            for (int i = 0; i < NUM_PCR; i++) begin
                if (main_idx == 4'(i + 1)) pcr[i] <= d;
            end
            if (main_idx == 4'(OFF_MCR)) mcr_q <= d;
            if (main_idx == 4'(OFF_RCR)) rcr_q <= d;
            // High byte is staged; it reaches the pointer only when the low
            // byte is written, so both halves change on the same edge.
            if (main_idx == 4'(OFF_P0H)) hold0_q <= d;
            if (main_idx == 4'(OFF_P0L)) begin
                p0l_q <= d;
                p0h_q <= hold0_q;
            end
            if (main_idx == 4'(OFF_P1H)) hold1_q <= d;
            if (main_idx == 4'(OFF_P1L)) begin
                p1l_q <= d;
                p1h_q <= hold1_q;
            end
            // VR is read-only: writes fall through with no effect.
        end else if (!rw && mirror_hit) begin
            if (mirror_idx == 4'd0) cr_q <= d;
            // LCR strobe: the written data is irrelevant, CR takes the PCR.
            for (int i = 0; i < NUM_PCR; i++) begin
                if (mirror_idx == 4'(i + 1)) cr_q <= pcr[i];
            end
        end
    end

    assign cr = cr_q;

    // -------------------------------------------------------------------------
    // Address translation
    // -------------------------------------------------------------------------
    logic [7:0]        page;
    logic [BANK_W-1:0] xlat_bank;

    always_comb begin
        page      = addr[15:8];
        xlat_bank = cr_q[7 -: BANK_W];
        if (addr[15:8] == 8'h00) begin
            page      = p0l_q;
            xlat_bank = p0h_q[BANK_W-1:0];
        end else if (addr[15:8] == p0l_q && p0l_q != 8'h00) begin
            // The page the zero page was moved onto is swapped back to page 0.
            page      = 8'h00;
            xlat_bank = '0;
        end else if (addr[15:8] == 8'h01) begin
            page      = p1l_q;
            xlat_bank = p1h_q[BANK_W-1:0];
        end else if (addr[15:8] == p1l_q && p1l_q != 8'h01) begin
            page      = 8'h01;
            xlat_bank = '0;
        end
    end

    assign ma = {page, addr[7:0]};

    // -------------------------------------------------------------------------
    // Common RAM forcing, applied to the translated address
    // -------------------------------------------------------------------------
    logic [5:0] size_kb;
    logic       in_bottom;
    logic       in_top;

    always_comb begin
        case (rcr_q[1:0])
            2'b00:   size_kb = 6'd1;
            2'b01:   size_kb = 6'd4;
            2'b10:   size_kb = 6'd8;
            default: size_kb = 6'd16;
        endcase
    end

    // Compare in 1 KB units: ma[15:10] is the kilobyte index of ma.
    assign in_bottom = rcr_q[2] && (ma[15:10] < size_kb);
    assign in_top    = rcr_q[3] && ({1'b0, ma[15:10]} >= (7'd64 - {1'b0, size_kb}));
    assign ram_bank  = (in_bottom || in_top) ? '0 : xlat_bank;

endmodule

// File: tb/tb_mmu_banked.sv
module tb_mmu_banked;

    localparam int N      = 4;
    localparam int BW     = 2;
    localparam int BASE_A = 16'hD500;
    localparam int MIRR_A = 16'hFF00;
    localparam int VER    = 8'h20;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          rw    = 1'b1;
    logic [15:0]   addr  = 16'h0000;
    logic [7:0]    d_drv = 8'h00;
    logic          d_oe  = 1'b0;
    tri1  [7:0]    d;
    wire           reg_hit;
    wire  [7:0]    cr;
    wire  [BW-1:0] ram_bank;
    wire  [15:0]   ma;

    // Undriven bus reads back as FF through the pull-up.
    assign d = d_oe ? d_drv : 8'bz;

    mmu_banked #(
        .BASE    (16'hD500),
        .MIRROR  (16'hFF00),
        .NUM_PCR (N),
        .BANK_W  (BW),
        .VERSION (8'h20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rw       (rw),
        .addr     (addr),
        .d        (d),
        .reg_hit  (reg_hit),
        .cr       (cr),
        .ram_bank (ram_bank),
        .ma       (ma)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ------------------------------------------------------------------
    // Reference model: register contents as plain integers
    // ------------------------------------------------------------------
    int m_cr, m_mcr, m_rcr, m_p0l, m_p0h, m_p1l, m_p1h, m_h0, m_h1;
    int m_pcr [N];
    int common_size [4] = '{1024, 4096, 8192, 16384};

    function automatic void model_reset();
        m_cr = 0; m_mcr = 0; m_rcr = 0;
        m_p0l = 0; m_p0h = 0; m_h0 = 0;
        m_p1l = 1; m_p1h = 0; m_h1 = 0;
        for (int i = 0; i < N; i++) m_pcr[i] = 0;
    endfunction

    function automatic void model_write(input int a, input int v);
        int off, moff;
        off  = a - BASE_A;
        moff = a - MIRR_A;
        if (off >= 0 && off < N + 8) begin
            if (off == 0)                     m_cr = v;
            else if (off <= N)                m_pcr[off-1] = v;
            else if (off == N + 1)            m_mcr = v;
            else if (off == N + 2)            m_rcr = v;
            else if (off == N + 3) begin      m_p0l = v; m_p0h = m_h0; end
            else if (off == N + 4)            m_h0 = v;
            else if (off == N + 5) begin      m_p1l = v; m_p1h = m_h1; end
            else if (off == N + 6)            m_h1 = v;
        end else if (moff >= 0 && moff <= N) begin
            if (moff == 0) m_cr = v;
            else           m_cr = m_pcr[moff-1];
        end
    endfunction

    // Returns -1 when the address is not a register.
    function automatic int model_read(input int a);
        int off, moff;
        off  = a - BASE_A;
        moff = a - MIRR_A;
        if (off >= 0 && off < N + 8) begin
            if (off == 0)      return m_cr;
            if (off <= N)      return m_pcr[off-1];
            if (off == N + 1)  return m_mcr;
            if (off == N + 2)  return m_rcr;
            if (off == N + 3)  return m_p0l;
            if (off == N + 4)  return m_p0h;
            if (off == N + 5)  return m_p1l;
            if (off == N + 6)  return m_p1h;
            return VER;
        end
        if (moff >= 0 && moff <= N) begin
            if (moff == 0) return m_cr;
            return m_pcr[moff-1];
        end
        return -1;
    endfunction

    function automatic void model_translate(input int a, output int e_ma, output int e_bank);
        int pg, bank, size, region, bmask;
        bmask = (1 << BW) - 1;
        pg    = a / 256;
        bank  = (m_cr >> (8 - BW)) & bmask;
        if (pg == 0) begin
            pg = m_p0l; bank = m_p0h & bmask;
        end else if (pg == m_p0l && m_p0l != 0) begin
            pg = 0; bank = 0;
        end else if (pg == 1) begin
            pg = m_p1l; bank = m_p1h & bmask;
        end else if (pg == m_p1l && m_p1l != 1) begin
            pg = 1; bank = 0;
        end
        e_ma   = pg * 256 + (a % 256);
        size   = common_size[m_rcr % 4];
        region = (m_rcr / 4) % 4;
        if ((region == 1 || region == 3) && e_ma < size)           bank = 0;
        if ((region == 2 || region == 3) && e_ma >= 65536 - size)  bank = 0;
        e_bank = bank;
    endfunction

    // ------------------------------------------------------------------
    // Bus tasks (every task starts and ends between clock edges)
    // ------------------------------------------------------------------
    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
        rw = 1'b0; addr = a; d_drv = v; d_oe = 1'b1;
        @(posedge clk);
        model_write(int'(a), int'(v));
        #1 rw = 1'b1; d_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
        rw = 1'b1; d_oe = 1'b0; addr = a;
        #2 v = d;
    endtask

    task automatic set_addr(input logic [15:0] a);
        rw = 1'b1; d_oe = 1'b0; addr = a;
        #2;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] exp;
        apply_reset(2);
        for (int i = 0; i < 12; i++) begin
            exp = (i == 9) ? 8'h01 : (i == 11) ? 8'h20 : 8'h00;
            bus_read(16'(BASE_A + i), v);
            n_total++;
            if (v !== exp) $display("FAIL reset_read[%0d]: got %h expected %h", i, v, exp);
            else n_pass++;
        end
        set_addr(16'h1234);
        n_total++;
        if (ma !== 16'h1234) $display("FAIL reset_ma: got %h expected 1234", ma);
        else n_pass++;
        n_total++;
        if (ram_bank !== 2'd0) $display("FAIL reset_bank: got %0d expected 0", ram_bank);
        else n_pass++;
    endtask

    task automatic test_cr_windows();
        logic [7:0] v;
        bus_write(16'hD500, 8'h55);
        bus_read(16'hFF00, v);
        n_total++;
        if (v !== 8'h55) $display("FAIL cr_mirror_read: got %h expected 55", v);
        else n_pass++;
        n_total++;
        if (cr !== 8'h55) $display("FAIL cr_out: got %h expected 55", cr);
        else n_pass++;
        bus_write(16'hFF00, 8'hC0);
        set_addr(16'h1234);
        n_total++;
        if (ram_bank !== 2'd3) $display("FAIL cr_bank: got %0d expected 3", ram_bank);
        else n_pass++;
        bus_read(16'hD500, v);
        n_total++;
        if (v !== 8'hC0) $display("FAIL cr_main_read: got %h expected c0", v);
        else n_pass++;
    endtask

    task automatic test_pcr_lcr();
        logic [7:0] v;
        bus_write(16'hD502, 8'h3F);
        bus_write(16'hFF02, 8'h00);
        n_total++;
        if (cr !== 8'h3F) $display("FAIL lcr_load: got %h expected 3f", cr);
        else n_pass++;
        bus_read(16'hFF02, v);
        n_total++;
        if (v !== 8'h3F) $display("FAIL lcr_read: got %h expected 3f", v);
        else n_pass++;
        bus_read(16'hD502, v);
        n_total++;
        if (v !== 8'h3F) $display("FAIL pcr_read: got %h expected 3f", v);
        else n_pass++;
    endtask

    task automatic test_page_pointers();
        logic [7:0] v;
        bus_write(16'hD508, 8'h01);
        bus_read(16'hD508, v);
        n_total++;
        if (v !== 8'h00) $display("FAIL p0h_staged: got %h expected 00", v);
        else n_pass++;
        bus_write(16'hD507, 8'h40);
        set_addr(16'h0012);
        n_total++;
        if (ma !== 16'h4012 || ram_bank !== 2'd1)
            $display("FAIL zp_reloc: got ma=%h bank=%0d expected ma=4012 bank=1", ma, ram_bank);
        else n_pass++;
        set_addr(16'h4012);
        n_total++;
        if (ma !== 16'h0012 || ram_bank !== 2'd0)
            $display("FAIL zp_swap: got ma=%h bank=%0d expected ma=0012 bank=0", ma, ram_bank);
        else n_pass++;
        bus_read(16'hD508, v);
        n_total++;
        if (v !== 8'h01) $display("FAIL p0h_commit: got %h expected 01", v);
        else n_pass++;
    endtask

    task automatic test_common_ram();
        bus_write(16'hD500, 8'h40);
        bus_write(16'hD506, 8'h05);
        set_addr(16'h0800);
        n_total++;
        if (ram_bank !== 2'd0) $display("FAIL common_in: got %0d expected 0", ram_bank);
        else n_pass++;
        set_addr(16'h2000);
        n_total++;
        if (ram_bank !== 2'd1) $display("FAIL common_out: got %0d expected 1", ram_bank);
        else n_pass++;
    endtask

    task automatic test_bus_and_decode();
        logic [15:0] hit_addr [6] = '{16'hD500, 16'hD50B, 16'hD50C, 16'hD4FF, 16'hFF04, 16'hFF05};
        logic        hit_exp  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_addr(hit_addr[i]);
            n_total++;
            if (reg_hit !== hit_exp[i])
                $display("FAIL reg_hit[%h]: got %b expected %b", hit_addr[i], reg_hit, hit_exp[i]);
            else n_pass++;
        end
        set_addr(16'h1234);
        n_total++;
        if (d !== 8'hFF) $display("FAIL float_read_miss: got %h expected ff", d);
        else n_pass++;
        // A write cycle to a register: only the bench may drive the bus.
        rw = 1'b0; addr = 16'hD501; d_drv = 8'h5A; d_oe = 1'b1;
        #2;
        n_total++;
        if (d !== 8'h5A) $display("FAIL float_write: got %h expected 5a", d);
        else n_pass++;
        @(posedge clk);
        model_write(16'hD501, 8'h5A);
        #1 rw = 1'b1; d_oe = 1'b0;
    endtask

    task automatic test_reset_during_write();
        logic [7:0] v;
        bus_write(16'hD500, 8'h11);
        rw = 1'b0; addr = 16'hD500; d_drv = 8'hAA; d_oe = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; rw = 1'b1; d_oe = 1'b0;
        model_reset();
        n_total++;
        if (cr !== 8'h00) $display("FAIL reset_wins: got %h expected 00", cr);
        else n_pass++;
        bus_read(16'hD501, v);
        n_total++;
        if (v !== 8'h00) $display("FAIL reset_pcr: got %h expected 00", v);
        else n_pass++;
    endtask

    task automatic test_random(input int iters);
        logic [15:0] a;
        logic [7:0]  v;
        int          kind, data, e_ma, e_bank, e_rd, pick;
        apply_reset(1);
        for (int it = 0; it < iters; it++) begin
            kind = $urandom_range(0, 9);
            data = $urandom_range(0, 255);
            if (kind <= 5)      a = 16'(BASE_A + $urandom_range(0, N + 8));
            else if (kind <= 7) a = 16'(MIRR_A + $urandom_range(0, N + 1));
            else                a = 16'($urandom_range(0, 65535));
            // Keep page pointers in a small range so swaps collide often.
            if (a == 16'(BASE_A + N + 3) || a == 16'(BASE_A + N + 5))
                if ($urandom_range(0, 1) == 1) data = $urandom_range(0, 4) * 64 / 64 + $urandom_range(0, 3);
            if (kind != 9) bus_write(a, 8'(data));

            n_total++;
            if (cr !== 8'(m_cr)) $display("FAIL rand_cr[%0d]: got %h expected %h", it, cr, 8'(m_cr));
            else n_pass++;

            pick = $urandom_range(0, 4);
            case (pick)
                0:       a = {8'h00, 8'($urandom)};
                1:       a = {8'h01, 8'($urandom)};
                2:       a = {8'(m_p0l), 8'($urandom)};
                3:       a = {8'(m_p1l), 8'($urandom)};
                default: a = 16'($urandom);
            endcase
            set_addr(a);
            model_translate(int'(a), e_ma, e_bank);
            n_total++;
            if (ma !== 16'(e_ma) || ram_bank !== BW'(e_bank))
                $display("FAIL rand_xlat[%0d] addr=%h: got ma=%h bank=%0d expected ma=%h bank=%0d",
                         it, a, ma, ram_bank, 16'(e_ma), e_bank);
            else n_pass++;

            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            else if ($urandom_range(0, 1) == 0) a = 16'(BASE_A + $urandom_range(0, N + 8));
            else a = 16'(MIRR_A + $urandom_range(0, N + 1));
            bus_read(a, v);
            e_rd = model_read(int'(a));
            n_total++;
            if (e_rd >= 0) begin
                if (v !== 8'(e_rd) || reg_hit !== 1'b1)
                    $display("FAIL rand_read[%0d] addr=%h: got d=%h hit=%b expected d=%h hit=1",
                             it, a, v, reg_hit, 8'(e_rd));
                else n_pass++;
            end else begin
                if (v !== 8'hFF || reg_hit !== 1'b0)
                    $display("FAIL rand_miss[%0d] addr=%h: got d=%h hit=%b expected d=ff hit=0",
                             it, a, v, reg_hit);
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cr_windows();
        test_pcr_lcr();
        test_page_pointers();
        test_common_ram();
        test_bus_and_decode();
        test_reset_during_write();
        test_random(400);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
